atom_npu_sequencer: RTL and testbench
=====================================

Name: atom_npu_sequencer

Overview:
Host-side initiator for the atom NPU core's start/done handshake.
- Buffers up to DEPTH (input, weight) nibble pairs from a host load port.
- On `go`, issues one core job per pair, holding the operands stable.
- Captures each 4-bit saturated product on core done and accumulates the products into a saturating dot-product sum.
- Presents the sum on a valid/ready result port.
- Sits between the host register interface and the core.

Parameters:
DEPTH, 4, operand-pair buffer entries (power of 2, ≥2)
SUM_W, 6, result accumulator width (≥4)
TIMEOUT, 16, max cycles in WAIT before aborting a job

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_valid  in  1  host offers an operand pair
load_ready  out  1  buffer can accept a pair (LOAD state, not full)
load_input  in  4  input operand
load_weight  in  4  weight operand
go  in  1  start a run over all buffered pairs
busy  out  1  high in ISSUE/WAIT/RESULT
core_start  out  1  one-cycle start pulse to core
core_input  out  4  operand to core, held for the whole job
core_weight  out  4  weight to core, held for the whole job
core_output  in  4  core result
core_done  in  1  core done level
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_sum  out  SUM_W  saturating sum of products
res_count  out  log2(DEPTH)+1  number of jobs completed in this run
timeout_err  out  1  run aborted by timeout; sticky until next accepted go

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: all outputs 0, except load_ready=1. Buffer count=0, state=LOAD.
- Reset mid-run: abandon the job immediately. core_start=0 from the next cycle. The core's own reset is driven separately at top level.

States:
- LOAD
  - load_ready = (count<DEPTH).
  - A pair is written when load_valid&&load_ready.
  - go with count_after_write>0 → ISSUE: idx=0, sum=0, res_count=0, timeout_err cleared. A load in the same cycle is included.
  - go with count 0 is ignored. go in any other state is ignored.
- ISSUE (1 cycle)
  - core_start=1; core_input/core_weight = buf[idx]. The operand outputs stay registered through WAIT.
  - → WAIT, timer=0.
- WAIT
  - core_done is ignored in the first WAIT cycle (the core clears done on the start edge). From then on, core_done=1 completes the job:
    - sum <= min(sum+core_output, 2^SUM_W-1);
    - res_count++, idx++;
    - if idx was count-1 → RESULT, else → ISSUE.
  - timer increments each cycle. timer==TIMEOUT-1 without done → RESULT with the partial sum, timeout_err=1.
- RESULT
  - res_valid=1. res_sum/res_count are stable until res_ready.
  - On res_valid&&res_ready: count=0, → LOAD. res_valid drops the next cycle.
  - res_sum/res_count hold their values afterwards, until the next go.

Timing and arithmetic:
- Nominal core timing: done is visible 7 cycles after the core_start cycle, so each job takes 8 cycles (ISSUE + 7 WAIT).
- Run latency: res_valid is asserted 8N+1 cycles after the go cycle, for N pairs.
- Arithmetic is unsigned. Zero products still count as completed jobs.
- Buffer contents are not cleared by a run; only count resets.

Test Plan:
- Reset, load (3,4),(2,3), go, res_ready=1 → core_start pulses twice 8 cycles apart; core_input/weight stable across each job; res_sum=18, res_count=2, res_valid 17 cycles after go, timeout_err=0.
- Load 4 × (15,15), SUM_W=6 → load_ready=0 after the 4th load; a 5th load_valid is not accepted; res_sum=60. Same run with SUM_W=5 → res_sum=31 (saturated).
- go with empty buffer → ignored (busy=0, no core_start). load_valid+go in the same cycle with (5,5) → one job, res_sum=15.
- Hold res_ready=0 for 10 cycles in RESULT → res_valid, res_sum and res_count stable. go pulsed during RESULT → ignored. Then res_ready=1 → back to LOAD, load_ready=1.
- Core model never asserts done (TIMEOUT=16) → RESULT reached 16 WAIT cycles after ISSUE; timeout_err=1, res_count=0, res_sum=0. The next accepted go clears timeout_err.
- Assert rst during WAIT of the 2nd job → next cycle: all outputs 0, load_ready=1, count=0. A subsequent load+go runs cleanly.

Source files
------------

// File: rtl/atom_npu_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// atom_npu_sequencer
//
// Host-side initiator for the atom NPU core's start/done handshake.
//
// The block buffers up to DEPTH (input, weight) nibble pairs from the host
// load port. On go it issues one core job per buffered pair, holding the
// operands stable for the whole job. It captures each 4-bit product on core
// done and accumulates the products into a saturating dot-product sum. The
// sum is then presented on a valid/ready result port.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   load_valid/ready: host operand-pair load handshake
//   load_input/weight: operand pair written into the buffer
//   go              : start a run over every buffered pair (honoured in LOAD only)
//   busy            : high while a run is in progress or its result is pending
//   core_start      : one-cycle start pulse to the core
//   core_input/weight: registered operands, held stable through each job
//   core_output     : core product (4-bit, already saturated by the core)
//   core_done       : core done level
//   res_valid/ready : result handshake
//   res_sum         : saturating sum of products of the last run
//   res_count       : number of jobs completed in the last run
//   timeout_err     : last run aborted by timeout; sticky until next accepted go
// -----------------------------------------------------------------------------
module atom_npu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int SUM_W   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [3:0]             load_input,
    input  logic [3:0]             load_weight,
    input  logic                   go,
    output logic                   busy,
    output logic                   core_start,
    output logic [3:0]             core_input,
    output logic [3:0]             core_weight,
    input  logic [3:0]             core_output,
    input  logic                   core_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SUM_W-1:0]       res_sum,
    output logic [$clog2(DEPTH):0] res_count,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0]    DEPTH_C    = CW'(DEPTH);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SUM_W-1:0] SUM_MAX    = {SUM_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [CW-1:0]     idx_reg, idx_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [SUM_W-1:0]  sum_reg, sum_next;
    logic [CW-1:0]     jobs_reg, jobs_next;
    logic              terr_reg, terr_next;
    logic [3:0]        op_in_reg, op_in_next;
    logic [3:0]        op_wt_reg, op_wt_next;

    // Operand-pair buffer; contents survive runs, only the count is cleared.
    logic [3:0]        in_mem [DEPTH];
    logic [3:0]        wt_mem [DEPTH];

    logic              load_fire;
    logic              go_fire;
    logic              done_fire;
    logic              time_fire;
    logic              last_job;
    logic [CW-1:0]     count_after;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [SUM_W:0]    sum_wide;

    assign wr_addr = count_reg[AW-1:0];

    always_comb begin
        load_fire   = (state_reg == ST_LOAD) && load_valid && (count_reg < DEPTH_C);
        count_after = count_reg + CW'(load_fire);
        // A pair loaded in the go cycle is part of the run.
        go_fire     = (state_reg == ST_LOAD) && go && (count_after != '0);
        // The first WAIT cycle may still see the previous job's done level.
        done_fire   = (state_reg == ST_WAIT) && (timer_reg != '0) && core_done;
        time_fire   = (state_reg == ST_WAIT) && !done_fire && (timer_reg == TIMER_LAST);
        last_job    = (idx_reg == (count_reg - CW'(1)));
        sum_wide    = {1'b0, sum_reg} + {{(SUM_W - 3){1'b0}}, core_output};

        state_next  = state_reg;
        count_next  = count_reg;
        idx_next    = idx_reg;
        timer_next  = timer_reg;
        sum_next    = sum_reg;
        jobs_next   = jobs_reg;
        terr_next   = terr_reg;
        op_in_next  = op_in_reg;
        op_wt_next  = op_wt_reg;

        case (state_reg)
            ST_LOAD: begin
                count_next = count_after;
                if (go_fire) begin
                    state_next = ST_ISSUE;
                    idx_next   = '0;
                    sum_next   = '0;
                    jobs_next  = '0;
                    terr_next  = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                timer_next = '0;
            end
            ST_WAIT: begin
                timer_next = timer_reg + TW'(1);
                if (done_fire) begin
                    sum_next   = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
                    jobs_next  = jobs_reg + CW'(1);
                    idx_next   = idx_reg + CW'(1);
                    state_next = last_job ? ST_RESULT : ST_ISSUE;
                end else if (time_fire) begin
                    state_next = ST_RESULT;
                    terr_next  = 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase

        // Operands are fetched into their output registers on the way into
        // ISSUE, so they are already valid during the start pulse and stay
        // put until the next job. Entry 0 written in the go cycle is not yet
        // in the buffer, so it is taken straight from the load port.
        rd_addr = idx_next[AW-1:0];
        if (state_next == ST_ISSUE) begin
            if (load_fire && (count_reg == '0)) begin
                op_in_next = load_input;
                op_wt_next = load_weight;
            end else begin
                op_in_next = in_mem[rd_addr];
                op_wt_next = wt_mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LOAD;
            count_reg <= '0;
            idx_reg   <= '0;
            timer_reg <= '0;
            sum_reg   <= '0;
            jobs_reg  <= '0;
            terr_reg  <= 1'b0;
            op_in_reg <= '0;
            op_wt_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            idx_reg   <= idx_next;
            timer_reg <= timer_next;
            sum_reg   <= sum_next;
            jobs_reg  <= jobs_next;
            terr_reg  <= terr_next;
            op_in_reg <= op_in_next;
            op_wt_reg <= op_wt_next;
        end
    end

    // Buffer write port; no reset so the arrays can map onto RAM.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            in_mem[wr_addr] <= load_input;
            wt_mem[wr_addr] <= load_weight;
        end
    end

    assign load_ready  = (state_reg == ST_LOAD) && (count_reg < DEPTH_C);
    assign busy        = (state_reg != ST_LOAD);
    assign core_start  = (state_reg == ST_ISSUE);
    assign core_input  = op_in_reg;
    assign core_weight = op_wt_reg;
    assign res_valid   = (state_reg == ST_RESULT);
    assign res_sum     = sum_reg;
    assign res_count   = jobs_reg;
    assign timeout_err = terr_reg;

endmodule

// File: tb/tb_atom_npu_sequencer.sv
`timescale 1ns/1ps
// Bench for atom_npu_sequencer: two instances (SUM_W=6 and SUM_W=5) share all
// inputs and one behavioural core model; results are compared against a
// queue-based model of the buffered pairs.
module tb_atom_npu_sequencer;

    localparam int DEPTH   = 4;
    localparam int SUM_W   = 6;
    localparam int SUM_W_B = 5;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_valid = 1'b0;
    logic go = 1'b0;
    logic res_ready = 1'b0;
    logic [3:0] load_input = '0;
    logic [3:0] load_weight = '0;

    logic load_ready, busy, core_start, res_valid, timeout_err;
    logic [3:0] core_input, core_weight;
    logic [SUM_W-1:0] res_sum;
    logic [CW-1:0] res_count;

    logic load_ready_b, busy_b, core_start_b, res_valid_b, timeout_err_b;
    logic [3:0] core_input_b, core_weight_b;
    logic [SUM_W_B-1:0] res_sum_b;
    logic [CW-1:0] res_count_b;

    logic core_done = 1'b0;
    logic [3:0] core_output = '0;

    always #5 clk = ~clk;

    atom_npu_sequencer #(.DEPTH(DEPTH), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_input(load_input), .load_weight(load_weight),
        .go(go), .busy(busy),
        .core_start(core_start), .core_input(core_input), .core_weight(core_weight),
        .core_output(core_output), .core_done(core_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_count(res_count), .timeout_err(timeout_err)
    );

    atom_npu_sequencer #(.DEPTH(DEPTH), .SUM_W(SUM_W_B), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_b),
        .load_input(load_input), .load_weight(load_weight),
        .go(go), .busy(busy_b),
        .core_start(core_start_b), .core_input(core_input_b), .core_weight(core_weight_b),
        .core_output(core_output), .core_done(core_done),
        .res_valid(res_valid_b), .res_ready(res_ready),
        .res_sum(res_sum_b), .res_count(res_count_b), .timeout_err(timeout_err_b)
    );

    function automatic int sat_prod(input int a, input int b);
        return (a * b > 15) ? 15 : a * b;
    endfunction

    // Core model: done rises lat cycles after the start cycle and stays high
    // until the next start (optionally one cycle into the next job).
    int lat = 7;
    bit no_done = 1'b0;
    bit late_clear = 1'b0;
    bit clr_pend = 1'b0;
    int ccnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            core_done   <= 1'b0;
            core_output <= '0;
            ccnt        <= 0;
            clr_pend    <= 1'b0;
        end else if (core_start) begin
            core_output <= 4'(sat_prod(int'(core_input), int'(core_weight)));
            ccnt        <= 1;
            if (late_clear) clr_pend <= 1'b1;
            else core_done <= 1'b0;
        end else begin
            if (clr_pend) begin
                core_done <= 1'b0;
                clr_pend  <= 1'b0;
            end
            if (ccnt != 0) begin
                if (ccnt == lat - 1) begin
                    ccnt <= 0;
                    if (!no_done) core_done <= 1'b1;
                end else begin
                    ccnt <= ccnt + 1;
                end
            end
        end
    end

    // Cycle counter and start/operand monitor (sampled on the falling edge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int start_cyc[$];
    int start_i[$];
    int start_w[$];
    int stab_err = 0;
    int twin_err = 0;
    logic [3:0] hold_i = '0;
    logic [3:0] hold_w = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) begin
                start_cyc.push_back(cyc);
                start_i.push_back(int'(core_input));
                start_w.push_back(int'(core_weight));
                hold_i = core_input;
                hold_w = core_weight;
            end else if (busy && !res_valid &&
                         (core_input !== hold_i || core_weight !== hold_w)) begin
                stab_err++;
            end
            if (core_start_b !== core_start || busy_b !== busy || res_valid_b !== res_valid ||
                load_ready_b !== load_ready || timeout_err_b !== timeout_err ||
                res_count_b !== res_count || core_input_b !== core_input ||
                core_weight_b !== core_weight)
                twin_err++;
        end
    end

    // Reference model: the pairs currently buffered, in load order.
    int q_i[$];
    int q_w[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_sum(input int w);
        int s = 0;
        foreach (q_i[k]) s += sat_prod(q_i[k], q_w[k]);
        return (s > (2 ** w) - 1) ? (2 ** w) - 1 : s;
    endfunction

    task automatic load_pair(input string tag, input int i, input int w);
        bit exp_acc;
        exp_acc = (q_i.size() < DEPTH);
        load_valid  = 1'b1;
        load_input  = 4'(i);
        load_weight = 4'(w);
        check({tag, " load_ready"}, int'(load_ready), int'(exp_acc));
        step();
        load_valid = 1'b0;
        if (exp_acc) begin
            q_i.push_back(i);
            q_w.push_back(w);
        end
    endtask

    task automatic start_run(input bit with_load, input int i, input int w, output int g);
        g = cyc;
        start_cyc.delete();
        start_i.delete();
        start_w.delete();
        stab_err = 0;
        go = 1'b1;
        if (with_load) begin
            load_valid  = 1'b1;
            load_input  = 4'(i);
            load_weight = 4'(w);
            if (q_i.size() < DEPTH) begin
                q_i.push_back(i);
                q_w.push_back(w);
            end
        end
        step();
        go = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int g, input bit exp_to,
                              input int hold, input bit go_in_result);
        int n = 0;
        int nj;
        int bad;
        int es;
        int es_b;
        nj   = exp_to ? 0 : q_i.size();
        es   = exp_to ? 0 : exp_sum(SUM_W);
        es_b = exp_to ? 0 : exp_sum(SUM_W_B);
        while (!res_valid && n < 3000) begin
            step();
            n++;
        end
        check({tag, " res_valid"}, int'(res_valid), 1);
        check({tag, " latency"}, cyc - g, exp_to ? TIMEOUT + 2 : nj * (lat + 1) + 1);
        check({tag, " starts"}, start_cyc.size(), exp_to ? 1 : nj);
        bad = 0;
        foreach (start_cyc[k]) begin
            if (!exp_to && start_cyc[k] != g + 1 + k * (lat + 1)) bad++;
            if (k < q_i.size() && (start_i[k] != q_i[k] || start_w[k] != q_w[k])) bad++;
        end
        check({tag, " start timing/operands"}, bad, 0);
        check({tag, " operand stability"}, stab_err, 0);
        check({tag, " twin agreement"}, twin_err, 0);
        check({tag, " res_count"}, int'(res_count), nj);
        check({tag, " res_sum"}, int'(res_sum), es);
        check({tag, " res_sum SUM_W=5"}, int'(res_sum_b), es_b);
        check({tag, " timeout_err"}, int'(timeout_err), int'(exp_to));
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            go = go_in_result;
            step();
            if (res_valid !== 1'b1 || int'(res_sum) != es || int'(res_count) != nj) bad++;
        end
        go = 1'b0;
        if (hold > 0) check({tag, " held result"}, bad, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, " res_valid drop"}, int'(res_valid), 0);
        check({tag, " back to load"}, int'(load_ready && !busy), 1);
        check({tag, " res_sum kept"}, int'(res_sum), es);
        check({tag, " timeout_err sticky"}, int'(timeout_err), int'(exp_to));
        q_i.delete();
        q_w.delete();
    endtask

    initial begin
        int g;
        int n;
        int nj;
        bit comb;

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        check("reset load_ready", int'(load_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset core_start", int'(core_start), 0);
        check("reset res_valid", int'(res_valid), 0);
        check("reset res_sum", int'(res_sum), 0);
        check("reset res_count", int'(res_count), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        check("reset core_operands", int'({core_input, core_weight}), 0);
        rst = 1'b0;
        step();

        // go with an empty buffer is ignored
        start_run(1'b0, 0, 0, g);
        check("empty go busy", int'(busy), 0);
        repeat (3) step();
        check("empty go starts", start_cyc.size(), 0);

        // Basic two-pair run: 12 + 6 = 18, 17 cycles
        lat = 7;
        load_pair("basic", 3, 4);
        load_pair("basic", 2, 3);
        start_run(1'b0, 0, 0, g);
        finish_run("basic", g, 1'b0, 0, 1'b0);

        // Full buffer of (15,15): fifth load refused, 60 / saturated 31
        for (int k = 0; k < 5; k++) load_pair("full", 15, 15);
        start_run(1'b0, 0, 0, g);
        finish_run("full", g, 1'b0, 0, 1'b0);

        // Load and go in the same cycle
        start_run(1'b1, 5, 5, g);
        finish_run("load+go", g, 1'b0, 0, 1'b0);

        // Result held for 10 cycles with go pulsed during RESULT
        load_pair("hold", 7, 3);
        load_pair("hold", 4, 2);
        start_run(1'b0, 0, 0, g);
        finish_run("hold", g, 1'b0, 10, 1'b1);

        // Core never answers: timeout with empty partial result
        no_done = 1'b1;
        load_pair("timeout", 9, 9);
        start_run(1'b0, 0, 0, g);
        finish_run("timeout", g, 1'b1, 0, 1'b0);
        no_done = 1'b0;
        load_pair("after timeout", 1, 2);
        start_run(1'b0, 0, 0, g);
        check("go clears timeout_err", int'(timeout_err), 0);
        check("go after timeout busy", int'(busy), 1);
        finish_run("after timeout", g, 1'b0, 0, 1'b0);

        // Reset during WAIT of the second job
        load_pair("midreset", 6, 2);
        load_pair("midreset", 3, 3);
        load_pair("midreset", 2, 2);
        start_run(1'b0, 0, 0, g);
        n = 0;
        while (start_cyc.size() < 2 && n < 200) begin
            step();
            n++;
        end
        check("midreset second start", start_cyc.size(), 2);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("midreset core_start", int'(core_start), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset load_ready", int'(load_ready), 1);
        check("midreset result", int'({res_valid, res_sum, res_count, timeout_err}), 0);
        check("midreset core_operands", int'({core_input, core_weight}), 0);
        rst = 1'b0;
        q_i.delete();
        q_w.delete();
        step();
        start_run(1'b1, 7, 2, g);
        finish_run("after reset", g, 1'b0, 0, 1'b0);

        // Randomized runs with varied core latency and done-clear behaviour
        for (int r = 0; r < 10; r++) begin
            lat        = $urandom_range(2, 9);
            late_clear = 1'($urandom_range(0, 1));
            nj         = $urandom_range(1, DEPTH);
            comb       = 1'($urandom_range(0, 1));
            for (int k = 0; k < nj - int'(comb); k++)
                load_pair($sformatf("rand%0d", r), $urandom_range(0, 15), $urandom_range(0, 15));
            start_run(comb, $urandom_range(0, 15), $urandom_range(0, 15), g);
            finish_run($sformatf("rand%0d", r), g, 1'b0, $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
